lsu_mem_master: RTL
===================

Name: lsu_mem_master

Overview:
- Load/store initiator that drives the word-wide on-chip SRAM port (rd_en, wr_en, word address, data_in, registered data_out with 1-cycle read latency). The SRAM is the responder; this block is the requesting side.
- Accepts byte/halfword/word load and store requests from the core through a valid/ready handshake, and returns one response per request.
- The SRAM has no byte enables, so sub-word stores are done as read-modify-write.
- Sits between the core's memory stage and the SRAM. At most one request is in flight at a time.

Parameters:
- ADDR_W, 16, SRAM word-address width. The byte address is ADDR_W+2 bits.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  sign-extend loads (ignored for word loads and stores)
- req_addr  in  ADDR_W+2  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  load result, zero/sign-extended; 0 for stores and errors
- resp_err  out  1  misaligned or illegal-size request
- mem_rd_en  out  1  SRAM read enable
- mem_wr_en  out  1  SRAM write enable
- mem_addr  out  ADDR_W  SRAM word address
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data, valid the cycle after mem_rd_en

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous, active-high, named rst.
- Reset: state=IDLE and all latched registers cleared.
  - Output values under reset: req_ready=0 while rst is high, 1 afterwards; resp_valid=0, resp_rdata=0, resp_err=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0.
- States: IDLE, RD, RDW, WR, RESP.
- Handshake:
  - req_ready=1 only in IDLE (and rst=0).
  - A request is accepted when req_valid && req_ready at a rising edge. Its fields are latched then.
  - Request inputs are not sampled in any other state.
- Request decode at accept:
  - word offset = req_addr[1:0]; word address = req_addr[ADDR_W+1:2].
  - Error if size=11, or half with addr[0]=1, or word with addr[1:0]!=0.
- Transitions from IDLE on accept:
  - error -> RESP with err=1; no SRAM access is issued.
  - load -> RD.
  - word store -> WR.
  - byte/half store -> RD.
- Other transitions:
  - RD -> RDW.
  - RDW:
    - load: extract lane and extend into the result register, -> RESP.
    - sub-word store: merge store data into the latched SRAM word, -> WR.
  - WR -> RESP.
  - RESP -> IDLE.
- SRAM port outputs are decoded from the state register only; there is no combinational path from req_* inputs.
  - mem_rd_en = (state==RD) && !rst.
  - mem_wr_en = (state==WR) && !rst.
  - mem_addr = latched word address in RD/RDW/WR/RESP; 0 in IDLE.
  - mem_wdata = write buffer in WR; 0 otherwise.
- Lanes are little-endian:
  - byte offset n occupies bits [8n+7:8n];
  - a half at offset 0 occupies [15:0], at offset 2 occupies [31:16].
- Loads: the selected lane is zero-extended, or sign-extended when req_signed=1.
- Stores:
  - word stores write req_wdata directly;
  - sub-word stores replace only the addressed lane with req_wdata[7:0] or [15:0], keeping the other lanes from mem_rdata.
- Response: resp_valid=1 for exactly one cycle, in RESP. resp_rdata and resp_err are held valid only in that cycle (0 otherwise). There is no response back-pressure.
- Latency, counting T as the accept edge's cycle:
  - load: mem_rd_en at T+1, resp at T+3;
  - word store: mem_wr_en at T+1, resp at T+2;
  - sub-word store: rd T+1, wr T+3, resp T+4;
  - error: resp at T+1.
  - Next accept is possible at the cycle after RESP.
- Reset mid-operation: rst in any state forces IDLE at the next edge. mem_wr_en and mem_rd_en are deasserted in the same cycle rst is high, so no partial RMW write reaches the SRAM. No response is generated for the aborted request.

Test Plan:
- Word store 0xDEADBEEF to byte addr 0x0010 -> T+1 mem_wr_en=1, mem_addr=0x0004, mem_wdata=0xDEADBEEF; resp_valid at T+2, resp_err=0. Then word load from 0x0010 -> mem_rd_en at T+1, resp_rdata=0xDEADBEEF at T+3.
- Byte store 0x5A to 0x0013 -> RD at T+1, WR at T+3 with mem_wdata=0x5AADBEEF, resp at T+4. Subsequent word load returns 0x5AADBEEF.
- Loads after the above:
  - signed half at 0x0012 -> 0x00005AAD;
  - signed byte at 0x0011 -> 0xFFFFFFBE;
  - unsigned byte at 0x0011 -> 0x000000BE.
- Misaligned word load at 0x0012, half store at 0x0011, and size=11 -> each gives resp_valid=1, resp_err=1, resp_rdata=0 at T+1; mem_rd_en and mem_wr_en never asserted.
- Assert rst during the WR cycle of a byte store to 0x0020 -> mem_wr_en=0 that cycle; IDLE next cycle; no resp_valid; the memory word at 0x0008 is unchanged.
- req_valid held high with 4 back-to-back word loads -> accepts spaced exactly 4 cycles apart; req_ready=0 outside IDLE; exactly one resp_valid per request, in order.

Source files
------------

// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-wide single-port SRAM without byte enables.
// One request in flight; sub-word stores are done as read-modify-write.
// SRAM port and response outputs decode from the state register only, so
// there is no combinational path from the request inputs to the SRAM.
module lsu_mem_master #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, RDW, WR, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  state_t            state_reg;
  logic              we_reg;
  logic [1:0]        size_reg;
  logic              signed_reg;
  logic [1:0]        off_reg;
  logic [ADDR_W-1:0] waddr_reg;
  logic [31:0]       wdata_reg;   // right-aligned store data from the core
  logic [31:0]       wbuf_reg;    // word that goes out on mem_wdata in WR
  logic [31:0]       result_reg;  // extended load result
  logic              err_reg;

  logic              req_err;
  logic [3:0][7:0]   rd_lanes;
  logic [3:0][7:0]   merge_word;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [31:0]       load_val;

  // Alignment / size check of the incoming request, used only at accept.
  always_comb begin
    req_err = 1'b0;
    if (req_size == SZ_ILL)
      req_err = 1'b1;
    else if (req_size == SZ_HALF && req_addr[0])
      req_err = 1'b1;
    else if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
      req_err = 1'b1;
  end

  assign rd_lanes = mem_rdata;
  assign sel_byte = rd_lanes[off_reg];
  assign sel_half = off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  // Lane extraction and zero/sign extension for loads.
  always_comb begin
    load_val = mem_rdata;
    case (size_reg)
      SZ_BYTE: load_val = {{24{signed_reg & sel_byte[7]}}, sel_byte};
      SZ_HALF: load_val = {{16{signed_reg & sel_half[15]}}, sel_half};
      default: load_val = mem_rdata;
    endcase
  end

  // Per-lane merge for sub-word stores: the addressed lane(s) take store
  // data, the others keep what the SRAM returned.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign merge_word[gi] =
        (size_reg == SZ_BYTE && off_reg == LANE)       ? wdata_reg[7:0] :
        (size_reg == SZ_HALF && off_reg[1] == LANE[1]) ? wdata_reg[8*(gi%2) +: 8] :
                                                         rd_lanes[gi];
  end

  // Request FSM: latch on accept, sequence SRAM access, one-cycle response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      we_reg     <= 1'b0;
      size_reg   <= 2'b00;
      signed_reg <= 1'b0;
      off_reg    <= 2'b00;
      waddr_reg  <= '0;
      wdata_reg  <= '0;
      wbuf_reg   <= '0;
      result_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            we_reg     <= req_we;
            size_reg   <= req_size;
            signed_reg <= req_signed;
            off_reg    <= req_addr[1:0];
            waddr_reg  <= req_addr[ADDR_W+1:2];
            wdata_reg  <= req_wdata;
            wbuf_reg   <= req_wdata;
            result_reg <= '0;
            err_reg    <= req_err;
            if (req_err)
              state_reg <= RESP;
            else if (req_we && req_size == SZ_WORD)
              state_reg <= WR;
            else
              state_reg <= RD;
          end
        end
        RD:  state_reg <= RDW;
        RDW: begin
          if (we_reg) begin
            wbuf_reg  <= merge_word;
            state_reg <= WR;
          end else begin
            result_reg <= load_val;
            state_reg  <= RESP;
          end
        end
        WR:  state_reg <= RESP;
        RESP: begin
          result_reg <= '0;
          err_reg    <= 1'b0;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Outputs are gated by rst so an aborted RMW never writes the SRAM.
  assign req_ready  = (state_reg == IDLE) && !rst;
  assign resp_valid = (state_reg == RESP) && !rst;
  assign resp_rdata = resp_valid ? result_reg : 32'h0;
  assign resp_err   = resp_valid ? err_reg : 1'b0;
  assign mem_rd_en  = (state_reg == RD) && !rst;
  assign mem_wr_en  = (state_reg == WR) && !rst;
  assign mem_addr   = (state_reg != IDLE && !rst) ? waddr_reg : '0;
  assign mem_wdata  = mem_wr_en ? wbuf_reg : 32'h0;

endmodule
